// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multicycle control FSM, ALU control and datapath
//
// Contents:
//   OP_*        7-bit opcode constants
//   ALU_OP_*    3-bit ALU_Op codes consumed by the ALU control
//   SRC_A_*, SRC_B_*, WB_*, PC_SRC_*   datapath mux-select encodings
//   state_t     4-bit FSM state encoding (also visible on state_o)
//   ctrl_t      bundle of state-decoded control outputs
//   decode_opcode / is_wait_state      helpers used by the FSM
package multicycle_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_OP_R    = 3'b000;
    localparam logic [2:0] ALU_OP_I    = 3'b001;
    localparam logic [2:0] ALU_OP_ADD  = 3'b010;
    localparam logic [2:0] ALU_OP_LUI  = 3'b100;
    localparam logic [2:0] ALU_OP_BR   = 3'b101;
    localparam logic [2:0] ALU_OP_JALR = 3'b111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_BR     = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JAL      = 4'd9,
        ST_JALR     = 4'd10,
        ST_LUI      = 4'd11,
        ST_ALU_WB   = 4'd12,
        ST_HALT     = 4'd13
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] wb_sel;
        logic [1:0] pc_src;
    } ctrl_t;

    // Successor of DECODE; anything unrecognised parks the FSM in HALT.
    function automatic state_t decode_opcode(input logic [6:0] op);
        case (op)
            OP_R:               return ST_EXEC_R;
            OP_I:               return ST_EXEC_I;
            OP_LOAD, OP_STORE:  return ST_MEM_ADDR;
            OP_BRANCH:          return ST_BRANCH;
            OP_JAL:             return ST_JAL;
            OP_JALR:            return ST_JALR;
            OP_LUI:             return ST_LUI;
            default:            return ST_HALT;
        endcase
    endfunction

    // States that wait on the memory handshake and are guarded by the timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - 4-bit memory wait counter with timeout compare
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clear        restart the count (FSM is entering a new state)
//   inc          one more cycle spent waiting for mem_ready_i
//   expired      count has reached MEM_TIMEOUT
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [3:0] LIMIT = 4'(MEM_TIMEOUT);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V style control FSM with memory timeout fault
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   opcode_i, zero_i           instruction opcode, ALU compare result
//   mem_ready_i                memory access completes this cycle
//   ir_write_o, pc_write_o     IR load, unconditional PC load
//   pc_cond_o                  PC load in BRANCH when zero_i is set
//   mem_read_o, mem_write_o    memory requests, i_or_d_o address select
//   reg_write_o                register file write
//   alu_src_a_o, alu_src_b_o, alu_op_o, wb_sel_o, pc_src_o   datapath selects
//   state_o                    current state (debug)
//   fault_o                    sticky illegal-opcode / memory-timeout flag
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_cond_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       i_or_d_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] pc_src_o,
    output logic [3:0] state_o,
    output logic       fault_o
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   fault;
    logic   wait_expired;
    logic   timed_out;

    // Completion wins over timeout when both happen in the same cycle.
    assign timed_out = is_wait_state(state) && !mem_ready_i && wait_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state),
        .inc     (is_wait_state(state) && !mem_ready_i),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            // Any fresh entry into HALT is a fault: illegal opcode or timeout.
            if (state_next == ST_HALT && state != ST_HALT) begin
                fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready_i)    state_next = ST_DECODE;
                else if (timed_out) state_next = ST_HALT;
            end
            ST_DECODE:   state_next = decode_opcode(opcode_i);
            ST_EXEC_R,
            ST_EXEC_I,
            ST_LUI:      state_next = ST_ALU_WB;
            ST_MEM_ADDR: state_next = (opcode_i == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready_i)    state_next = ST_MEM_WB;
                else if (timed_out) state_next = ST_HALT;
            end
            ST_MEM_WR: begin
                if (mem_ready_i)    state_next = ST_FETCH;
                else if (timed_out) state_next = ST_HALT;
            end
            ST_ALU_WB,
            ST_MEM_WB,
            ST_BRANCH,
            ST_JAL,
            ST_JALR:     state_next = ST_FETCH;
            ST_HALT:     state_next = ST_HALT;
            default:     state_next = ST_HALT;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                // The fetched word and PC+4 are captured only on the completing cycle.
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = SRC_A_OLD_PC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_OP_R;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_I;
            end
            ST_LUI: begin
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_LUI;
            end
            ST_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_ALU;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_MEM;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_OP_BR;
                ctrl.pc_src    = PC_SRC_BR;
            end
            ST_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_ALUOUT;
            end
            ST_JALR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_JALR;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.pc_write  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_PC4;
            end
            default: ctrl = '0;
        endcase
    end

    // Strobes are gated by reset directly so an in-flight access drops at once,
    // without waiting for the state register to be observed.
    assign ir_write_o  = ctrl.ir_write  & reset;
    assign pc_write_o  = ctrl.pc_write  & reset;
    assign pc_cond_o   = (state == ST_BRANCH) & zero_i & reset;
    assign mem_read_o  = ctrl.mem_read  & reset;
    assign mem_write_o = ctrl.mem_write & reset;
    assign reg_write_o = ctrl.reg_write & reset;
    assign i_or_d_o    = ctrl.i_or_d;
    assign alu_src_a_o = ctrl.alu_src_a;
    assign alu_src_b_o = ctrl.alu_src_b;
    assign alu_op_o    = ctrl.alu_op;
    assign wb_sel_o    = ctrl.wb_sel;
    assign pc_src_o    = ctrl.pc_src;
    assign state_o     = state;
    assign fault_o     = fault;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3;
    localparam logic [3:0] MEM_ADDR = 4'd4, MEM_RD = 4'd5, MEM_WB = 4'd6, MEM_WR = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8, JAL = 4'd9, JALR = 4'd10, LUI = 4'd11;
    localparam logic [3:0] ALU_WB = 4'd12, HALT = 4'd13;

    localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011, BEQ = 7'b1100011, JALO = 7'b1101111;
    localparam logic [6:0] JALRO = 7'b1100111, LUIO = 7'b0110111, BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       flt, irw, pcw, pcc, mrd, mwr, rgw, iod;
        logic [1:0] sa, sb;
        logic [2:0] op;
        logic [1:0] wb, ps;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode_i = '0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       ir_write_o, pc_write_o, pc_cond_o, mem_read_o, mem_write_o;
    logic       i_or_d_o, reg_write_o, fault_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, wb_sel_o, pc_src_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;

    obs_t expq[$];
    obs_t mskq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_cond_o(pc_cond_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .i_or_d_o(i_or_d_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .wb_sel_o(wb_sel_o),
        .pc_src_o(pc_src_o), .state_o(state_o), .fault_o(fault_o)
    );

    // Expected outputs for a state; the mask marks the fields that state defines.
    function automatic void exp_obs(input logic r, input logic rdy, input logic z,
                                    input logic [3:0] st, input logic f,
                                    output obs_t e, output obs_t m);
        e = '0;
        m = '0;
        e.st = st; e.flt = f;
        m.st = '1; m.flt = 1'b1; m.irw = 1'b1; m.pcw = 1'b1; m.pcc = 1'b1;
        m.mrd = 1'b1; m.mwr = 1'b1; m.rgw = 1'b1;
        if (r) begin
            case (st)
                FETCH:    begin e.mrd = 1; e.irw = rdy; e.pcw = rdy; m.iod = 1;
                                e.sb = 2'b01; e.op = 3'b010; m.sa = '1; m.sb = '1; m.op = '1; end
                DECODE:   begin e.sa = 2'b10; e.sb = 2'b10; e.op = 3'b010;
                                m.sa = '1; m.sb = '1; m.op = '1; end
                EXEC_R:   begin e.op = 3'b000; e.sb = 2'b00; m.op = '1; m.sb = '1; end
                EXEC_I:   begin e.op = 3'b001; e.sb = 2'b10; m.op = '1; m.sb = '1; end
                LUI:      begin e.op = 3'b100; e.sb = 2'b10; m.op = '1; m.sb = '1; end
                ALU_WB:   begin e.rgw = 1; e.wb = 2'b00; m.wb = '1; end
                MEM_ADDR: begin e.op = 3'b010; e.sa = 2'b01; e.sb = 2'b10;
                                m.op = '1; m.sa = '1; m.sb = '1; end
                MEM_RD:   begin e.mrd = 1; e.iod = 1; m.iod = 1; end
                MEM_WB:   begin e.rgw = 1; e.wb = 2'b01; m.wb = '1; end
                MEM_WR:   begin e.mwr = 1; e.iod = 1; m.iod = 1; end
                BRANCH:   begin e.op = 3'b101; e.sa = 2'b01; e.sb = 2'b00; e.ps = 2'b10; e.pcc = z;
                                m.op = '1; m.sa = '1; m.sb = '1; m.ps = '1; end
                JAL:      begin e.rgw = 1; e.wb = 2'b10; e.pcw = 1; e.ps = 2'b01;
                                m.wb = '1; m.ps = '1; end
                JALR:     begin e.op = 3'b111; e.sa = 2'b01; e.sb = 2'b10; e.ps = 2'b00;
                                e.pcw = 1; e.rgw = 1; e.wb = 2'b10;
                                m.op = '1; m.sa = '1; m.sb = '1; m.ps = '1; m.wb = '1; end
                default:  ;
            endcase
        end
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic step(input logic r, input logic [6:0] op, input logic z,
                        input logic rdy, input logic [3:0] st, input logic f);
        obs_t e, m;
        reset = r; opcode_i = op; zero_i = z; mem_ready_i = rdy;
        exp_obs(r, rdy, z, st, f, e, m);
        expq.push_back(e);
        mskq.push_back(m);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            obs_t act, e, m;
            act = {state_o, fault_o, ir_write_o, pc_write_o, pc_cond_o, mem_read_o,
                   mem_write_o, reg_write_o, i_or_d_o, alu_src_a_o, alu_src_b_o,
                   alu_op_o, wb_sel_o, pc_src_o};
            e = expq.pop_front();
            m = mskq.pop_front();
            checks++;
            if (((act ^ e) & m) !== '0) begin
                errors++;
                $display("FAIL obs#%0d t=%0t act=%h exp=%h mask=%h", checks, $time, act, e, m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // reset held: FETCH with strobes suppressed
        step(0, ADD, 0, 1, FETCH, 0);
        step(0, ADD, 0, 1, FETCH, 0);
        // ADD: 4 cycles
        step(1, ADD, 0, 1, FETCH, 0);
        step(1, ADD, 0, 1, DECODE, 0);
        step(1, ADD, 0, 1, EXEC_R, 0);
        step(1, ADD, 0, 1, ALU_WB, 0);
        // LW with 3 not-ready cycles in MEM_RD: 8 cycles
        step(1, LW, 0, 1, FETCH, 0);
        step(1, LW, 0, 1, DECODE, 0);
        step(1, LW, 0, 1, MEM_ADDR, 0);
        step(1, LW, 0, 0, MEM_RD, 0);
        step(1, LW, 0, 0, MEM_RD, 0);
        step(1, LW, 0, 0, MEM_RD, 0);
        step(1, LW, 0, 1, MEM_RD, 0);
        step(1, LW, 0, 1, MEM_WB, 0);
        // ADDI, LUI, JAL, JALR, SW; FETCH waits twice before ADDI
        step(1, ADDI, 0, 0, FETCH, 0);
        step(1, ADDI, 0, 0, FETCH, 0);
        step(1, ADDI, 0, 1, FETCH, 0);
        step(1, ADDI, 0, 1, DECODE, 0);
        step(1, ADDI, 0, 1, EXEC_I, 0);
        step(1, ADDI, 0, 1, ALU_WB, 0);
        step(1, LUIO, 0, 1, FETCH, 0);
        step(1, LUIO, 0, 1, DECODE, 0);
        step(1, LUIO, 0, 1, LUI, 0);
        step(1, LUIO, 0, 1, ALU_WB, 0);
        step(1, JALO, 0, 1, FETCH, 0);
        step(1, JALO, 0, 1, DECODE, 0);
        step(1, JALO, 0, 1, JAL, 0);
        step(1, JALRO, 0, 1, FETCH, 0);
        step(1, JALRO, 0, 1, DECODE, 0);
        step(1, JALRO, 0, 1, JALR, 0);
        step(1, SW, 0, 1, FETCH, 0);
        step(1, SW, 0, 1, DECODE, 0);
        step(1, SW, 0, 1, MEM_ADDR, 0);
        step(1, SW, 0, 1, MEM_WR, 0);
        // BEQ taken then not taken
        step(1, BEQ, 1, 1, FETCH, 0);
        step(1, BEQ, 1, 1, DECODE, 0);
        step(1, BEQ, 1, 1, BRANCH, 0);
        step(1, BEQ, 0, 1, FETCH, 0);
        step(1, BEQ, 0, 1, DECODE, 0);
        step(1, BEQ, 0, 1, BRANCH, 0);
        // SW timeout: 16 not-ready cycles in MEM_WR, then HALT with fault
        step(1, SW, 0, 1, FETCH, 0);
        step(1, SW, 0, 1, DECODE, 0);
        step(1, SW, 0, 1, MEM_ADDR, 0);
        for (int i = 0; i < 16; i++) step(1, SW, 0, 0, MEM_WR, 0);
        step(1, SW, 0, 1, HALT, 1);
        step(1, SW, 0, 1, HALT, 1);
        step(0, SW, 0, 1, FETCH, 0);
        // SW with ready arriving when the count sits at the limit
        step(1, SW, 0, 1, FETCH, 0);
        step(1, SW, 0, 1, DECODE, 0);
        step(1, SW, 0, 1, MEM_ADDR, 0);
        for (int i = 0; i < 15; i++) step(1, SW, 0, 0, MEM_WR, 0);
        step(1, SW, 0, 1, MEM_WR, 0);
        step(1, SW, 0, 1, FETCH, 0);
        step(1, SW, 0, 1, DECODE, 0);
        step(1, SW, 0, 1, MEM_ADDR, 0);
        step(1, SW, 0, 0, MEM_WR, 0);
        step(1, SW, 0, 0, MEM_WR, 0);
        // reset during MEM_WR: write drops at once, FETCH after release
        step(0, SW, 0, 0, FETCH, 0);
        step(1, SW, 0, 0, FETCH, 0);
        step(1, SW, 0, 1, FETCH, 0);
        // illegal opcode: HALT with fault, no strobes even with ready/zero high
        step(1, BAD, 0, 1, DECODE, 0);
        step(1, BAD, 1, 1, HALT, 1);
        step(1, ADD, 1, 1, HALT, 1);
        step(1, LW, 1, 1, HALT, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
